// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC register, fetch buffer, redirect handling
// Holds the PC, captures imem words into a small FIFO and offers them to decode over valid/ready.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pcplus4,
   output logic        misalign_err
);
   localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [31:0]   pc;
   logic [AW:0]   count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          err;
   logic [31:0]   buf_instr [DEPTH];
   logic [31:0]   buf_pc    [DEPTH];
   logic          pop;
   logic          push;

   assign out_valid = (count != '0);
   assign pop  = out_valid && out_ready && !redirect_valid;
   // a full buffer can still accept when the head leaves in the same cycle
   assign push = !err && !redirect_valid && ((count < FULL) || pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc     <= RESET_PC;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         err    <= 1'b0;
      end else if (redirect_valid) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         if (redirect_pc[1:0] == 2'b00)
            pc <= redirect_pc;
         else
            err <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            pc     <= pc + 32'd4;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + (AW + 1)'(1);
         else if (pop && !push)
            count <= count - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_instr[wr_ptr] <= imem_instr;
         buf_pc[wr_ptr]    <= pc;
      end
   end

   assign imem_pc      = pc;
   assign misalign_err = err;
   assign out_instr    = buf_instr[rd_ptr];
   assign out_pc       = buf_pc[rd_ptr];
   assign out_pcplus4  = buf_pc[rd_ptr] + 32'd4;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;
   localparam int MDEPTH = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_ready = 1'b0;

   logic [31:0] imem_pc0, imem_instr0, out_instr0, out_pc0, out_pcplus40;
   logic        out_valid0, misalign_err0;
   logic [31:0] imem_pc1, imem_instr1, out_instr1, out_pc1, out_pcplus41;
   logic        out_valid1, misalign_err1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_pc;
   logic        m_err;
   logic [31:0] m_q [$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'h0:   mem = 32'h0000_07b7;
         32'h4:   mem = 32'h0007_8793;
         32'h8:   mem = 32'h0640_0713;
         default: mem = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
      endcase
   endfunction

   assign imem_instr0 = mem(imem_pc0);
   assign imem_instr1 = mem(imem_pc1);

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
      .clk(clk), .reset(reset), .imem_pc(imem_pc0), .imem_instr(imem_instr0),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0),
      .out_pc(out_pc0), .out_pcplus4(out_pcplus40), .misalign_err(misalign_err0)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
      .clk(clk), .reset(reset), .imem_pc(imem_pc1), .imem_instr(imem_instr1),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1),
      .out_pc(out_pc1), .out_pcplus4(out_pcplus41), .misalign_err(misalign_err1)
   );

   // one clock of stimulus; the model advances by the fetch rules using the pre-edge view
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
      logic vld, p_pop, p_push;
      redirect_valid = rv;
      redirect_pc    = rpc;
      out_ready      = rdy;
      vld    = (m_q.size() != 0);
      p_pop  = vld && rdy && !rv;
      p_push = !m_err && !rv && ((m_q.size() < MDEPTH) || p_pop);
      @(posedge clk);
      if (rv) begin
         m_q.delete();
         if (rpc[1:0] != 2'b00) m_err = 1'b1;
         else m_pc = rpc;
      end else begin
         if (p_pop) void'(m_q.pop_front());
         if (p_push) begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(negedge clk);
      redirect_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      m_pc = 32'h0;
      m_err = 1'b0;
      m_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (out_valid0 !== 1'b0 || imem_pc0 !== 32'h0 || misalign_err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b pc=%h err=%b, required valid=0 pc=0 err=0",
                  out_valid0, imem_pc0, misalign_err0);
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_in [3];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
      exp_in[0] = 32'h0000_07b7; exp_in[1] = 32'h0007_8793; exp_in[2] = 32'h0640_0713;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         n_checks++;
         if (out_valid0 !== 1'b1 || out_pc0 !== exp_pc[i] || out_instr0 !== exp_in[i] ||
             out_pcplus40 !== exp_pc[i] + 32'd4) begin
            n_fail++;
            $display("FAIL stream_%0d: valid=%b pc=%h instr=%h pc4=%h, required valid=1 pc=%h instr=%h pc4=%h",
                     i, out_valid0, out_pc0, out_instr0, out_pcplus40, exp_pc[i], exp_in[i], exp_pc[i] + 32'd4);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
      n_checks++;
      if (out_valid0 !== 1'b1 || imem_pc0 !== 32'h8 || out_pc0 !== 32'h0) begin
         n_fail++;
         $display("FAIL backpressure_hold: valid=%b imem_pc=%h out_pc=%h, required 1 00000008 00000000",
                  out_valid0, imem_pc0, out_pc0);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (out_valid0 !== 1'b1 || out_pc0 !== 32'(i * 4) || imem_pc0 !== 32'(i * 4 + 8)) begin
            n_fail++;
            $display("FAIL full_stream_%0d: valid=%b out_pc=%h imem_pc=%h, required 1 %h %h",
                     i, out_valid0, out_pc0, imem_pc0, 32'(i * 4), 32'(i * 4 + 8));
         end
         cycle(1'b0, 32'h0, 1'b1);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_pc0 !== 32'h8) begin
         n_fail++;
         $display("FAIL redirect_setup: out_pc=%h, required 00000008", out_pc0);
      end
      cycle(1'b1, 32'h40, 1'b1);
      n_checks++;
      if (out_valid0 !== 1'b0 || imem_pc0 !== 32'h40) begin
         n_fail++;
         $display("FAIL redirect_bubble: valid=%b imem_pc=%h, required 0 00000040", out_valid0, imem_pc0);
      end
      cycle(1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid0 !== 1'b1 || out_pc0 !== 32'h40 || out_instr0 !== mem(32'h40)) begin
         n_fail++;
         $display("FAIL redirect_target: valid=%b pc=%h instr=%h, required 1 00000040 %h",
                  out_valid0, out_pc0, out_instr0, mem(32'h40));
      end
   endtask

   task automatic test_misalign();
      logic [31:0] frozen;
      do_reset();
      cycle(1'b0, 32'h0, 1'b1);
      frozen = imem_pc0;
      cycle(1'b1, 32'h42, 1'b1);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (misalign_err0 !== 1'b1 || out_valid0 !== 1'b0 || imem_pc0 !== frozen) begin
            n_fail++;
            $display("FAIL misalign_%0d: err=%b valid=%b imem_pc=%h, required 1 0 %h",
                     i, misalign_err0, out_valid0, imem_pc0, frozen);
         end
         cycle(1'b0, 32'h0, 1'($urandom_range(0, 1)));
      end
      cycle(1'b1, 32'h80, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         n_checks++;
         if (misalign_err0 !== 1'b1 || out_valid0 !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_sticky_%0d: err=%b valid=%b, required 1 0", i, misalign_err0, out_valid0);
         end
      end
      do_reset();
      n_checks++;
      if (misalign_err0 !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_clear: err=%b, required 0", misalign_err0);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 1'b1);
         n_checks++;
         if (out_valid1 !== 1'b1 || out_pc1 !== exp_pc[i] || out_pcplus41 !== exp_pc[i] + 32'd4 ||
             out_instr1 !== mem(exp_pc[i])) begin
            n_fail++;
            $display("FAIL wrap_%0d: valid=%b pc=%h pc4=%h instr=%h, required 1 %h %h %h",
                     i, out_valid1, out_pc1, out_pcplus41, out_instr1, exp_pc[i], exp_pc[i] + 32'd4,
                     mem(exp_pc[i]));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (out_valid0 !== 1'b0 || imem_pc0 !== 32'h0 || imem_pc1 !== 32'hFFFF_FFF8) begin
         n_fail++;
         $display("FAIL async_reset: valid=%b pc0=%h pc1=%h, required 0 00000000 fffffff8",
                  out_valid0, imem_pc0, imem_pc1);
      end
      do_reset();
   endtask

   task automatic test_random();
      logic        rv;
      logic [31:0] rpc;
      int          err_age;
      do_reset();
      err_age = 0;
      for (int c = 0; c < 600; c++) begin
         n_checks++;
         if (out_valid0 !== (m_q.size() != 0) || imem_pc0 !== m_pc || misalign_err0 !== m_err ||
             (m_q.size() != 0 && (out_pc0 !== m_q[0] || out_instr0 !== mem(m_q[0]) ||
                                  out_pcplus40 !== m_q[0] + 32'd4))) begin
            n_fail++;
            $display("FAIL random_c%0d: valid=%b imem_pc=%h err=%b pc=%h instr=%h, required valid=%b imem_pc=%h err=%b pc=%h",
                     c, out_valid0, imem_pc0, misalign_err0, out_pc0, out_instr0,
                     (m_q.size() != 0), m_pc, m_err, (m_q.size() != 0) ? m_q[0] : 32'h0);
         end
         if (m_err) err_age++;
         if (err_age > 6) begin
            do_reset();
            err_age = 0;
         end else begin
            rv  = ($urandom_range(0, 9) == 0);
            rpc = {$urandom_range(0, 32'hFFFF) , 16'h0} | 32'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cycle(rv, rpc, 1'($urandom_range(0, 3) != 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misalign();
      test_wrap();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
